// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM state and job configuration for the conv window dispatcher
package conv_pkg;
  localparam int F = 3;
  localparam int N_MAX = 64;
  localparam int K_MAX = 16;
  localparam int NPE = 64;
  localparam int PEW = $clog2(NPE);
  localparam int IDXW = 24;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [7:0] n;
    logic [4:0] k;
    logic [1:0] s;
    logic       p;
    logic [7:0] out;
  } conv_cfg_t;
  function automatic logic [7:0] calc_out(input logic [7:0] n, input logic [1:0] s, input logic p);
    logic signed [9:0] t;
    t = {2'b00, n} - 10'(F) + {8'd0, p, 1'b0};
    return 8'((s == 2'd2 ? t >>> 1 : t) + 10'sd1);
  endfunction
endpackage

// File: rtl/pe_prio_pick.sv
// pe_prio_pick: lowest-set-bit finder used to choose the next free PE
module pe_prio_pick #(
  parameter int NPE = 64,
  parameter int PEW = $clog2(NPE)
) (
  input  logic [NPE-1:0] req,
  output logic [PEW-1:0] idx,
  output logic           found
);
  assign found = |req;
  always_comb begin
    idx = '0;
    for (int i = NPE - 1; i >= 0; i--) if (req[i]) idx = PEW'(i);
  end
endmodule

// File: rtl/conv_window_dispatcher.sv
// conv_window_dispatcher: walks every conv output window and dispatches each one
// to the lowest free PE over valid/ready, then waits for all PEs to complete.
module conv_window_dispatcher
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        cfg_n,
  input  logic [4:0]        cfg_k,
  input  logic [1:0]        cfg_stride,
  input  logic              cfg_pad,
  input  logic [NPE-1:0]    pe_busy,
  input  logic [NPE-1:0]    pe_done,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [PEW-1:0]    disp_pe,
  output logic [7:0]        disp_ox,
  output logic [7:0]        disp_oy,
  output logic [4:0]        disp_ch,
  output logic [IDXW-1:0]   disp_idx,
  output logic [F*F-1:0]    disp_padmsk,
  output logic              busy,
  output logic              done,
  output logic              err_cfg
);
  localparam int OW = PEW + 1;
  localparam int CW = PEW + 2;
  state_t state, state_nx;
  conv_cfg_t cfg;
  logic [OW-1:0] outstanding, cnt_nx;
  logic [CW-1:0] cnt_sum;
  logic [NPE-1:0] alloc, alloc_nx, free_nx;
  logic [PEW-1:0] pick_idx;
  logic pick_found, acc, lx, ly, last, cfg_bad, launch;
  logic [10:0] bx, by;
  logic [F*F-1:0] msk;

  assign acc = disp_valid && disp_ready;
  assign lx = disp_ox == cfg.out - 8'd1;
  assign ly = disp_oy == cfg.out - 8'd1;
  assign last = lx && ly && disp_ch == cfg.k - 5'd1;
  assign cfg_bad = cfg_n < 8'(F) || cfg_n > 8'(N_MAX) || cfg_k == 5'd0 || cfg_k > 5'(K_MAX) ||
                   !(cfg_stride == 2'd1 || cfg_stride == 2'd2);
  assign launch = state == IDLE && start && !abort && !cfg_bad;
  assign alloc_nx = (alloc & ~pe_done) | (acc ? {{(NPE-1){1'b0}}, 1'b1} << disp_pe : '0);
  assign free_nx = ~pe_busy & ~alloc_nx;
  assign cnt_sum = CW'(outstanding) + CW'(acc) - CW'($countones(pe_done & alloc));
  assign cnt_nx = cnt_sum > CW'(NPE) ? OW'(NPE) : cnt_sum[OW-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;

  pe_prio_pick #(.NPE(NPE), .PEW(PEW)) u_pick (.req(free_nx), .idx(pick_idx), .found(pick_found));

  // Negative tap coordinates wrap to large unsigned values, so one compare catches both edges.
  assign bx = 11'(cfg.s == 2'd2 ? {disp_ox, 1'b0} : {1'b0, disp_ox}) - 11'(cfg.p);
  assign by = 11'(cfg.s == 2'd2 ? {disp_oy, 1'b0} : {1'b0, disp_oy}) - 11'(cfg.p);
  always_comb begin
    msk = '0;
    for (int r = 0; r < F; r++)
      for (int c = 0; c < F; c++)
        msk[r*F+c] = (bx + 11'(c) >= 11'(cfg.n)) || (by + 11'(r) >= 11'(cfg.n));
  end
  assign disp_padmsk = disp_valid ? msk : '0;

  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (state == IDLE) state_nx = launch ? SCAN : IDLE;
    else if (state == SCAN) state_nx = acc && last ? DRAIN : SCAN;
    else if (state == DRAIN) state_nx = outstanding == '0 ? DONE : DRAIN;
    else state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cfg <= '0;
      alloc <= '0;
      outstanding <= '0;
      disp_valid <= 1'b0;
      disp_pe <= '0;
      disp_ox <= '0;
      disp_oy <= '0;
      disp_ch <= '0;
      disp_idx <= '0;
      err_cfg <= 1'b0;
    end else begin
      state <= state_nx;
      err_cfg <= state == IDLE && start && !abort && cfg_bad;
      if (abort) begin
        alloc <= '0;
        outstanding <= '0;
        disp_valid <= 1'b0;
      end else begin
        alloc <= alloc_nx;
        outstanding <= cnt_nx;
        if (launch) begin
          cfg <= '{n: cfg_n, k: cfg_k, s: cfg_stride, p: cfg_pad, out: calc_out(cfg_n, cfg_stride, cfg_pad)};
          disp_ox <= '0;
          disp_oy <= '0;
          disp_ch <= '0;
          disp_idx <= '0;
          disp_valid <= 1'b0;
        end else if (state == SCAN) begin
          if (acc) begin
            disp_ox <= lx ? '0 : disp_ox + 8'd1;
            disp_oy <= lx ? (ly ? '0 : disp_oy + 8'd1) : disp_oy;
            disp_ch <= lx && ly ? disp_ch + 5'd1 : disp_ch;
            disp_idx <= disp_idx + IDXW'(1);
          end
          // A pending offer keeps its PE; a new pick happens only once the slot frees up.
          if (!disp_valid || disp_ready) begin
            disp_valid <= pick_found && !(acc && last);
            disp_pe <= pick_idx;
          end
        end
      end
    end
endmodule

// File: tb/tb_conv_window_dispatcher.sv
// tb_conv_window_dispatcher: table-driven and randomized checks against a queue-based window model.
module tb_conv_window_dispatcher;
  import conv_pkg::*;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, cfg_pad = 1'b0, disp_ready = 1'b0;
  logic [7:0] cfg_n = '0;
  logic [4:0] cfg_k = '0;
  logic [1:0] cfg_stride = '0;
  logic [NPE-1:0] pe_busy = '0, pe_done = '0;
  logic disp_valid, busy, done, err_cfg;
  logic [PEW-1:0] disp_pe;
  logic [7:0] disp_ox, disp_oy;
  logic [4:0] disp_ch;
  logic [IDXW-1:0] disp_idx;
  logic [F*F-1:0] disp_padmsk;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  conv_window_dispatcher dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_stride(cfg_stride), .cfg_pad(cfg_pad),
    .pe_busy(pe_busy), .pe_done(pe_done),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pe(disp_pe),
    .disp_ox(disp_ox), .disp_oy(disp_oy), .disp_ch(disp_ch), .disp_idx(disp_idx),
    .disp_padmsk(disp_padmsk), .busy(busy), .done(done), .err_cfg(err_cfg)
  );

  always @(negedge clk)
    if (rstn) assert (dut.outstanding <= 7'(NPE)) else $error("FAIL outstanding exceeds NPE: %0d", dut.outstanding);

  typedef struct {int ox; int oy; int ch; int idx; logic [8:0] msk;} win_t;
  typedef struct {int n; int k; int s; int p; bit err; int cnt;} vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lowest(input logic [NPE-1:0] m);
    for (int i = 0; i < NPE; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic drive_cfg(input int n, input int k, input int s, input int p);
    cfg_n = 8'(n);
    cfg_k = 5'(k);
    cfg_stride = 2'(s);
    cfg_pad = 1'(p);
  endtask

  task automatic run_job(input int n, input int k, input int s, input int p,
                         input logic [NPE-1:0] pbusy, input int rdy_pct, input int exp_cnt);
    win_t q[$];
    win_t w;
    logic [NPE-1:0] am, dn;
    int o, got, pend_pe, lf, x, y, j;
    bit pend, seen, first, acc;
    o = (n - F + 2 * p) / s + 1;
    for (int ch = 0; ch < k; ch++)
      for (int oy = 0; oy < o; oy++)
        for (int ox = 0; ox < o; ox++) begin
          w.ox = ox; w.oy = oy; w.ch = ch; w.idx = ch * o * o + oy * o + ox; w.msk = '0;
          for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++) begin
              x = ox * s - p + c;
              y = oy * s - p + r;
              if (x < 0 || x >= n || y < 0 || y >= n) w.msk[r*F+c] = 1'b1;
            end
          q.push_back(w);
        end
    am = '0; got = 0; seen = 0; pend = 0; pend_pe = 0; first = 1;
    pe_busy = pbusy; pe_done = '0; disp_ready = 1'b0;
    drive_cfg(n, k, s, p);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_cfg_on_good_cfg", err_cfg, 0);
    for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
      lf = lowest(~pbusy & ~am);
      chk("busy_during_job", busy, 1);
      if (q.size() == 0) chk("offer_after_last", disp_valid, 0);
      else if (disp_valid) begin
        chk("ox", disp_ox, q[0].ox);
        chk("oy", disp_oy, q[0].oy);
        chk("ch", disp_ch, q[0].ch);
        chk("idx", disp_idx, q[0].idx);
        chk("padmsk", disp_padmsk, q[0].msk);
        chk("pe_is_free", pbusy[disp_pe] | am[disp_pe], 0);
        if (pend) chk("pe_held", disp_pe, pend_pe);
        else chk("pe_lowest_free", disp_pe, lf);
      end else if (!first) chk("stall_only_when_no_free_pe", lf >= 0, 0);
      if (done) begin
        seen = 1;
        chk("done_with_work_left", q.size() + $countones(am), 0);
      end
      first = 0;
      disp_ready = $urandom_range(99) < rdy_pct;
      dn = '0;
      for (int i = 0; i < NPE; i++) if (am[i] && $urandom_range(99) < 30) dn[i] = 1'b1;
      if ($urandom_range(9) == 0) begin
        j = $urandom_range(NPE - 1);
        if (!am[j]) dn[j] = 1'b1;
      end
      pe_done = dn;
      acc = disp_valid && disp_ready;
      pend = disp_valid && !disp_ready;
      pend_pe = disp_pe;
      am = am & ~dn;
      if (acc) begin
        am[disp_pe] = 1'b1;
        got++;
        if (q.size() != 0) void'(q.pop_front());
      end
      @(negedge clk);
    end
    chk("done_seen", seen, 1);
    chk("dispatch_count", got, exp_cnt);
    chk("done_single_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    pe_done = '0;
    disp_ready = 1'b0;
    if (!seen) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  task automatic run_bad(input int n, input int k, input int s, input int p);
    drive_cfg(n, k, s, p);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_cfg_pulse", err_cfg, 1);
    chk("busy_after_reject", busy, 0);
    @(negedge clk);
    chk("err_cfg_single_cycle", err_cfg, 0);
    chk("no_dispatch_after_reject", disp_valid, 0);
    chk("still_idle_after_reject", busy, 0);
  endtask

  vec_t vt[$];
  int accepts, rn, rk, rs, rp, ro;
  logic [IDXW-1:0] hold_idx;
  logic [PEW-1:0] hold_pe;
  logic [8:0] hold_msk;

  initial begin
    vt = '{
      '{5, 1, 1, 0, 0, 9},  '{4, 1, 2, 1, 0, 4},  '{2, 1, 1, 0, 1, 0},  '{5, 0, 1, 0, 1, 0},
      '{65, 1, 1, 0, 1, 0}, '{5, 17, 1, 0, 1, 0}, '{5, 1, 3, 0, 1, 0},  '{5, 1, 0, 0, 1, 0},
      '{3, 2, 1, 1, 0, 18}, '{7, 2, 2, 0, 0, 18}, '{6, 1, 2, 1, 0, 9},  '{3, 1, 2, 0, 0, 1},
      '{8, 3, 2, 1, 0, 48}, '{64, 1, 2, 0, 0, 961}
    };
    repeat (2) @(negedge clk);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_pe", disp_pe, 0);
    chk("rst_disp_ox", disp_ox, 0);
    chk("rst_disp_oy", disp_oy, 0);
    chk("rst_disp_ch", disp_ch, 0);
    chk("rst_disp_idx", disp_idx, 0);
    chk("rst_disp_padmsk", disp_padmsk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cfg", err_cfg, 0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      if (vt[i].err) run_bad(vt[i].n, vt[i].k, vt[i].s, vt[i].p);
      else run_job(vt[i].n, vt[i].k, vt[i].s, vt[i].p, '0, (i % 2) ? 100 : 70, vt[i].cnt);
    end

    // only PE 5 can be allocated: every dispatch waits for its completion
    run_job(5, 1, 1, 0, ~(64'd1 << 5), 100, 9);

    // backpressure: offer held 4 cycles, then exactly one accept
    drive_cfg(5, 1, 1, 0);
    pe_busy = '0;
    disp_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10 && !disp_valid; c++) @(negedge clk);
    chk("hold_offer_seen", disp_valid, 1);
    chk("hold_first_idx", disp_idx, 0);
    chk("hold_first_pe", disp_pe, 0);
    hold_idx = disp_idx; hold_pe = disp_pe; hold_msk = disp_padmsk;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        drive_cfg(9, 2, 2, 1);
        start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      chk("hold_valid", disp_valid, 1);
      chk("hold_idx_stable", disp_idx, hold_idx);
      chk("hold_pe_stable", disp_pe, hold_pe);
      chk("hold_msk_stable", disp_padmsk, hold_msk);
    end
    start = 1'b0;
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    chk("after_one_accept_idx", disp_idx, 1);
    chk("after_one_accept_pe", disp_pe, 1);
    @(negedge clk);
    chk("no_second_accept_idx", disp_idx, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_hold_idle", busy, 0);

    // abort after three accepts; late completions must be ignored
    drive_cfg(5, 1, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    disp_ready = 1'b1;
    accepts = 0;
    for (int c = 0; c < 20 && accepts < 3; c++) begin
      if (disp_valid) accepts++;
      if (accepts < 3) @(negedge clk);
    end
    chk("abort_three_accepts", accepts, 3);
    @(negedge clk);
    disp_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_no_valid", disp_valid, 0);
    chk("abort_no_done", done, 0);
    pe_done = 64'h7;
    @(negedge clk);
    pe_done = '0;
    chk("abort_late_done_no_pulse", done, 0);
    run_job(5, 1, 1, 0, '0, 100, 9);

    // randomized jobs against the model
    for (int t = 0; t < 6; t++) begin
      rn = $urandom_range(16, 3);
      rk = $urandom_range(3, 1);
      rs = $urandom_range(2, 1);
      rp = $urandom_range(1, 0);
      ro = (rn - F + 2 * rp) / rs + 1;
      run_job(rn, rk, rs, rp, {$urandom, $urandom} & {$urandom, $urandom}, $urandom_range(100, 40), rk * ro * ro);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
